// File: rtl/arp_ipv4_mac_cam_pkg.sv
// Shared types and constants for the ARP IPv4->MAC CAM insert/delete controller.
// Holds the FSM state enum, completion status codes and way geometry.
package arp_ipv4_mac_cam_pkg;

    localparam int WAYS     = 4;
    localparam int WAY_W    = 2;
    localparam int STATUS_W = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_WAIT,
        S_CHOOSE,
        S_WRITE,
        S_RESP
    } state_e;

    typedef logic [STATUS_W-1:0] status_t;

    localparam status_t STAT_NEW      = 3'd0;
    localparam status_t STAT_UPDATE   = 3'd1;
    localparam status_t STAT_EVICT    = 3'd2;
    localparam status_t STAT_DEL_OK   = 3'd3;
    localparam status_t STAT_DEL_MISS = 3'd4;
    localparam status_t STAT_TIMEOUT  = 3'd5;

    // Lowest-index clear bit; returns 0 when the vector is full (caller checks full separately).
    function automatic logic [WAY_W-1:0] lowest_free(input logic [WAYS-1:0] vec);
        lowest_free = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (!vec[i]) lowest_free = WAY_W'(i);
        end
    endfunction

endpackage

// File: rtl/arp_ipv4_mac_cam_valid_table.sv
// Per-set way-valid storage for the CAM, with lowest-free-way and set-full
// detection on a single combinational read port.
module arp_ipv4_mac_cam_valid_table
    import arp_ipv4_mac_cam_pkg::*;
#(
    parameter int SETS  = 16,
    parameter int SET_W = $clog2(SETS)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [SET_W-1:0] rd_set_i,
    output logic [WAY_W-1:0] free_way_o,
    output logic             full_o,
    input  logic             wr_en_i,
    input  logic [SET_W-1:0] wr_set_i,
    input  logic [WAY_W-1:0] wr_way_i,
    input  logic             wr_bit_i
);

    logic [WAYS-1:0] valid_q [SETS];
    logic [WAYS-1:0] rd_vec;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
        end else if (wr_en_i) begin
            valid_q[wr_set_i][wr_way_i] <= wr_bit_i;
        end
    end

    assign rd_vec     = valid_q[rd_set_i];
    assign free_way_o = lowest_free(rd_vec);
    assign full_o     = &rd_vec;

endmodule

// File: rtl/arp_ipv4_mac_cam_insert_ctrl.sv
// ARP CAM insert/delete controller: lookup the key, pick a way (update, free,
// or random evict), write the entry and report a completion status.
//
// state  | meaning
// IDLE   | ready for a request
// LOOKUP | issue one-cycle CAM lookup for captured key
// WAIT   | wait for lookup response, bounded by TIMEOUT
// CHOOSE | select way and status from hit/valid/Mod
// WRITE  | one-cycle CAM entry write, valid table update
// RESP   | one-cycle completion pulse
module arp_ipv4_mac_cam_insert_ctrl
    import arp_ipv4_mac_cam_pkg::*;
#(
    parameter int SETS    = 16,
    parameter int KEY_W   = 32,
    parameter int VAL_W   = 48,
    parameter int TIMEOUT = 64
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic                     ReqValid,
    output logic                     ReqReady,
    input  logic                     ReqOp,
    input  logic [KEY_W-1:0]         ReqKey,
    input  logic [VAL_W-1:0]         ReqValue,
    output logic                     LkpValid,
    output logic [KEY_W-1:0]         LkpKey,
    input  logic                     LkpRspValid,
    input  logic                     LkpHit,
    input  logic [WAY_W-1:0]         LkpWay,
    input  logic [WAY_W-1:0]         Mod,
    output logic                     WrEn,
    output logic [$clog2(SETS)-1:0]  WrSet,
    output logic [WAY_W-1:0]         WrWay,
    output logic [KEY_W-1:0]         WrKey,
    output logic [VAL_W-1:0]         WrValue,
    output logic                     WrValidBit,
    output logic                     RspValid,
    output logic [STATUS_W-1:0]      RspStatus,
    output logic [WAY_W-1:0]         RspWay
);

    localparam int SET_W = $clog2(SETS);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_e            state_q, state_d;
    logic              op_q, op_d;
    logic [KEY_W-1:0]  key_q, key_d;
    logic [VAL_W-1:0]  val_q, val_d;
    logic              hit_q, hit_d;
    logic [WAY_W-1:0]  lway_q, lway_d;
    logic [WAY_W-1:0]  way_q, way_d;
    status_t           status_q, status_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [WAY_W-1:0]  free_way;
    logic              set_full;

    arp_ipv4_mac_cam_valid_table #(
        .SETS (SETS)
    ) u_valid_table (
        .clk_i      (Clk),
        .rst_i      (Rst),
        .rd_set_i   (key_q[SET_W-1:0]),
        .free_way_o (free_way),
        .full_o     (set_full),
        .wr_en_i    (WrEn),
        .wr_set_i   (key_q[SET_W-1:0]),
        .wr_way_i   (way_q),
        .wr_bit_i   (!op_q)
    );

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q  <= S_IDLE;
            op_q     <= 1'b0;
            key_q    <= '0;
            val_q    <= '0;
            hit_q    <= 1'b0;
            lway_q   <= '0;
            way_q    <= '0;
            status_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            key_q    <= key_d;
            val_q    <= val_d;
            hit_q    <= hit_d;
            lway_q   <= lway_d;
            way_q    <= way_d;
            status_q <= status_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        key_d    = key_q;
        val_d    = val_q;
        hit_d    = hit_q;
        lway_d   = lway_q;
        way_d    = way_q;
        status_d = status_q;
        cnt_d    = cnt_q;
        LkpValid = 1'b0;
        WrEn     = 1'b0;
        RspValid = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (ReqValid) begin
                    op_d    = ReqOp;
                    key_d   = ReqKey;
                    val_d   = ReqValue;
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                LkpValid = 1'b1;
                cnt_d    = CNT_W'(TIMEOUT - 1);
                state_d  = S_WAIT;
            end
            S_WAIT: begin
                if (LkpRspValid) begin
                    hit_d   = LkpHit;
                    lway_d  = LkpWay;
                    state_d = S_CHOOSE;
                end else if (cnt_q == '0) begin
                    status_d = STAT_TIMEOUT;
                    way_d    = '0;
                    state_d  = S_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_CHOOSE: begin
                state_d = S_WRITE;
                if (!op_q) begin
                    // A hit updates in place even if that way's valid bit is clear.
                    if (hit_q) begin
                        way_d    = lway_q;
                        status_d = STAT_UPDATE;
                    end else if (!set_full) begin
                        way_d    = free_way;
                        status_d = STAT_NEW;
                    end else begin
                        way_d    = Mod;
                        status_d = STAT_EVICT;
                    end
                end else if (hit_q) begin
                    way_d    = lway_q;
                    status_d = STAT_DEL_OK;
                end else begin
                    way_d    = '0;
                    status_d = STAT_DEL_MISS;
                    state_d  = S_RESP;
                end
            end
            S_WRITE: begin
                WrEn    = 1'b1;
                state_d = S_RESP;
            end
            S_RESP: begin
                RspValid = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign ReqReady   = (state_q == S_IDLE) && !Rst;
    assign LkpKey     = key_q;
    assign WrSet      = key_q[SET_W-1:0];
    assign WrWay      = way_q;
    assign WrKey      = key_q;
    assign WrValue    = val_q;
    assign WrValidBit = WrEn && !op_q;
    assign RspStatus  = status_q;
    assign RspWay     = way_q;

endmodule
